// File: rtl/byte_striping_tx.sv
// byte_striping_tx: round-robin byte striper over up to 4 lanes.
// Define STRIPE_ALIGN_EN for aligned mode (lane groups emitted together, PAD-filled on gap timeout).
module byte_striping_tx #(
  parameter int LANES = 4,
  parameter int IDLE_GAP = 4,
  parameter logic [7:0] PAD = 8'hBC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [7:0] data_out2,
  output logic [7:0] data_out3,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       valid_out2,
  output logic       valid_out3,
  output logic [1:0] lane_ptr
);
`ifdef STRIPE_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam logic [1:0] LAST = 2'(LANES - 1);
  localparam logic [3:0] GAP = 4'(IDLE_GAP);
  typedef enum logic [1:0] {IDLE, STRIPE, FLUSH} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [3:0] gap, gap_n;
  logic [7:0] hold [4];
  logic [7:0] hold_n [4];
  logic [7:0] dout [4];
  logic [7:0] dout_n [4];
  logic [3:0] vout, vout_n;
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    gap_n = gap;
    hold_n = hold;
    dout_n = dout;
    vout_n = '0;
    if (ALIGN && state == FLUSH)
      for (int i = 0; i < LANES; i++) begin
        dout_n[i] = hold[i];
        vout_n[i] = 1'b1;
      end
    if (valid) begin
      state_n = STRIPE;
      gap_n = '0;
      ptr_n = (ptr == LAST) ? 2'd0 : ptr + 2'd1;
      hold_n[ptr] = data;
      if (!ALIGN) begin
        dout_n[ptr] = data;
        vout_n[ptr] = 1'b1;
      end else if (ptr == LAST)
        for (int i = 0; i < LANES; i++) begin
          dout_n[i] = hold_n[i];
          vout_n[i] = 1'b1;
        end
    end else if (state == STRIPE) begin
      gap_n = gap + {3'b000, gap != 4'hF};
      if (gap_n == GAP) begin
        gap_n = '0;
        ptr_n = 2'd0;
        state_n = (ALIGN && ptr != 2'd0) ? FLUSH : IDLE;
        if (ALIGN)
          for (int i = 0; i < 4; i++)
            if (2'(i) >= ptr) hold_n[i] = PAD;
      end
    end else state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      gap <= '0;
      hold <= '{default: 8'h00};
      dout <= '{default: 8'h00};
      vout <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      gap <= gap_n;
      hold <= hold_n;
      dout <= dout_n;
      vout <= vout_n;
    end
  end
  assign data_out0 = dout[0];
  assign data_out1 = dout[1];
  assign data_out2 = dout[2];
  assign data_out3 = dout[3];
  assign valid_out0 = vout[0];
  assign valid_out1 = vout[1];
  assign valid_out2 = vout[2];
  assign valid_out3 = vout[3];
  assign lane_ptr = ptr;
endmodule

// File: tb/tb_byte_striping_tx.sv
// tb_byte_striping_tx: table-driven check of a 4-lane striper plus a 2-lane sequence.
module tb_byte_striping_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic av0, av1, av2, av3, bv0, bv1, bv2, bv3;
  logic [1:0] ap, bp;
  always #5 clk = ~clk;
  byte_striping_tx dut (.clk(clk), .reset(reset), .valid(valid), .data(data),
    .data_out0(a0), .data_out1(a1), .data_out2(a2), .data_out3(a3),
    .valid_out0(av0), .valid_out1(av1), .valid_out2(av2), .valid_out3(av3), .lane_ptr(ap));
  byte_striping_tx #(.LANES(2)) dut2 (.clk(clk), .reset(reset), .valid(valid), .data(data),
    .data_out0(b0), .data_out1(b1), .data_out2(b2), .data_out3(b3),
    .valid_out0(bv0), .valid_out1(bv1), .valid_out2(bv2), .valid_out3(bv3), .lane_ptr(bp));
  typedef struct {
    logic r;
    logic v;
    logic [7:0] d;
    logic [31:0] ed;
    logic [3:0] ev;
    logic [1:0] ep;
  } vec_t;
  vec_t tv[$];
  int checks = 0;
  int fails = 0;
  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic [31:0] ed, input logic [3:0] ev, input logic [1:0] ep);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.ed = ed; x.ev = ev; x.ep = ep;
    tv.push_back(x);
  endtask
  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    reset = r;
    valid = v;
    data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [37:0] got, input logic [37:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) add(1, 0, 8'h00, 32'h0, 4'h0, 2'd0);
`ifndef STRIPE_ALIGN_EN
    add(0, 1, 8'h01, 32'h00000001, 4'b0001, 2'd1);
    add(0, 1, 8'h02, 32'h00000201, 4'b0010, 2'd2);
    add(0, 1, 8'h03, 32'h00030201, 4'b0100, 2'd3);
    add(0, 1, 8'h04, 32'h04030201, 4'b1000, 2'd0);
    add(0, 1, 8'h05, 32'h04030205, 4'b0001, 2'd1);
    add(0, 1, 8'h06, 32'h04030605, 4'b0010, 2'd2);
    add(0, 1, 8'h07, 32'h04070605, 4'b0100, 2'd3);
    add(0, 1, 8'h08, 32'h08070605, 4'b1000, 2'd0);
    add(1, 1, 8'hAA, 32'h0, 4'h0, 2'd0);
    add(0, 1, 8'h01, 32'h00000001, 4'b0001, 2'd1);
    add(0, 1, 8'h02, 32'h00000201, 4'b0010, 2'd2);
    add(0, 0, 8'h00, 32'h00000201, 4'b0000, 2'd2);
    add(0, 0, 8'h00, 32'h00000201, 4'b0000, 2'd2);
    add(0, 1, 8'h03, 32'h00030201, 4'b0100, 2'd3);
    add(1, 0, 8'h00, 32'h0, 4'h0, 2'd0);
    add(0, 1, 8'h01, 32'h00000001, 4'b0001, 2'd1);
    add(0, 1, 8'h02, 32'h00000201, 4'b0010, 2'd2);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 32'h00000201, 4'b0000, 2'd2);
    add(0, 0, 8'h00, 32'h00000201, 4'b0000, 2'd0);
    add(0, 1, 8'h09, 32'h00000209, 4'b0001, 2'd1);
`else
    add(0, 1, 8'h01, 32'h0, 4'h0, 2'd1);
    add(0, 1, 8'h02, 32'h0, 4'h0, 2'd2);
    add(0, 1, 8'h03, 32'h0, 4'h0, 2'd3);
    add(0, 1, 8'h04, 32'h04030201, 4'hF, 2'd0);
    add(0, 1, 8'h05, 32'h04030201, 4'h0, 2'd1);
    add(0, 1, 8'h06, 32'h04030201, 4'h0, 2'd2);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 32'h04030201, 4'h0, 2'd2);
    add(0, 0, 8'h00, 32'h04030201, 4'h0, 2'd0);
    add(0, 0, 8'h00, 32'hBCBC0605, 4'hF, 2'd0);
    add(0, 0, 8'h00, 32'hBCBC0605, 4'h0, 2'd0);
    add(0, 1, 8'h07, 32'hBCBC0605, 4'h0, 2'd1);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 32'hBCBC0605, 4'h0, 2'd1);
    add(0, 0, 8'h00, 32'hBCBC0605, 4'h0, 2'd0);
    add(0, 1, 8'h08, 32'hBCBCBC07, 4'hF, 2'd1);
    add(0, 1, 8'h09, 32'hBCBCBC07, 4'h0, 2'd2);
    add(0, 1, 8'h0A, 32'hBCBCBC07, 4'h0, 2'd3);
    add(0, 1, 8'h0B, 32'h0B0A0908, 4'hF, 2'd0);
    add(0, 1, 8'h01, 32'h0B0A0908, 4'h0, 2'd1);
    add(0, 1, 8'h02, 32'h0B0A0908, 4'h0, 2'd2);
    add(0, 1, 8'h03, 32'h0B0A0908, 4'h0, 2'd3);
    add(1, 1, 8'h04, 32'h0, 4'h0, 2'd0);
    add(0, 1, 8'h11, 32'h0, 4'h0, 2'd1);
    add(0, 1, 8'h12, 32'h0, 4'h0, 2'd2);
    add(0, 1, 8'h13, 32'h0, 4'h0, 2'd3);
    add(0, 1, 8'h14, 32'h14131211, 4'hF, 2'd0);
`endif
    foreach (tv[k]) begin
      drive(tv[k].r, tv[k].v, tv[k].d);
      chk($sformatf("vec%0d", k), {a3, a2, a1, a0, av3, av2, av1, av0, ap},
          {tv[k].ed, tv[k].ev, tv[k].ep});
    end
    drive(1, 1, 8'h55);
    chk("l2_reset", {b3, b2, b1, b0, bv3, bv2, bv1, bv0, bp}, 38'h0);
    for (int i = 1; i <= 4; i++) begin
      logic [7:0] e0, e1;
      logic [3:0] ev;
      drive(0, 1, 8'(i));
`ifndef STRIPE_ALIGN_EN
      e0 = (i % 2 == 1) ? 8'(i) : 8'(i - 1);
      e1 = (i % 2 == 1) ? ((i == 1) ? 8'h00 : 8'(i - 1)) : 8'(i);
      ev = (i % 2 == 1) ? 4'b0001 : 4'b0010;
`else
      e0 = (i <= 2) ? ((i == 2) ? 8'h01 : 8'h00) : ((i == 4) ? 8'h03 : 8'h01);
      e1 = (i <= 2) ? ((i == 2) ? 8'h02 : 8'h00) : ((i == 4) ? 8'h04 : 8'h02);
      ev = (i % 2 == 0) ? 4'b0011 : 4'b0000;
`endif
      chk($sformatf("l2_byte%0d", i), {b3, b2, b1, b0, bv3, bv2, bv1, bv0, bp},
          {16'h0000, e1, e0, ev, 2'(i % 2)});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
